// File: rtl/reg_access_arbiter_if.sv
// reg_access_arbiter_if: requester command lanes and register-bank drive for reg_access_arbiter
interface reg_access_arbiter_if #(
  parameter int NUM_REGS = 4,
  parameter int SEL_W    = 2
);
  logic                req_a, req_b;
  logic [3:0]          cmd_a, cmd_b;
  logic [SEL_W-1:0]    sel_a, sel_b;
  logic [15:0]         data_a, data_b;
  logic [NUM_REGS-1:0] e;
  logic [2:0]          fun_sel;
  logic [15:0]         i_data;
  logic                ack_a, ack_b, err, busy;
  modport master (
    output req_a, cmd_a, sel_a, data_a, req_b, cmd_b, sel_b, data_b,
    input  e, fun_sel, i_data, ack_a, ack_b, err, busy
  );
  modport slave (
    input  req_a, cmd_a, sel_a, data_a, req_b, cmd_b, sel_b, data_b,
    output e, fun_sel, i_data, ack_a, ack_b, err, busy
  );
endinterface

// File: rtl/reg_access_arbiter.sv
// reg_access_arbiter: round-robin sharing of a register bank between two requesters, one or two beats per command
module reg_access_arbiter #(
  parameter int NUM_REGS = 4,
  parameter int SEL_W    = 2
) (
  input logic                 clk,
  input logic                 rst,
  reg_access_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BEAT1 = 2'd1;
  localparam logic [1:0] BEAT2 = 2'd2;
  logic [1:0]          state_q, state_d;
  logic                rr_last_q, rr_last_d;
  logic                side_q, side_d;
  logic                split_q, split_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [7:0]          data_hi_q, data_hi_d;
  logic [NUM_REGS-1:0] e_q, e_d;
  logic [2:0]          fun_sel_q, fun_sel_d;
  logic [15:0]         i_q, i_d;
  logic                ack_a_q, ack_a_d, ack_b_q, ack_b_d, err_q, err_d, busy_q, busy_d;
  logic                gnt_b, fin;
  logic [3:0]          cmd_n;
  logic [SEL_W-1:0]    sel_n;
  logic [15:0]         data_n;
  function automatic logic in_rng(input logic [SEL_W-1:0] s);
    return 32'(s) < NUM_REGS;
  endfunction
  function automatic logic [NUM_REGS-1:0] onehot(input logic [SEL_W-1:0] s);
    return in_rng(s) ? {{(NUM_REGS-1){1'b0}}, 1'b1} << s : '0;
  endfunction
  // rr_last_q=1 means B was granted last, so A wins the next tie
  always_comb begin
    gnt_b     = bus.req_b & (~bus.req_a | ~rr_last_q);
    cmd_n     = gnt_b ? bus.cmd_b : bus.cmd_a;
    sel_n     = gnt_b ? bus.sel_b : bus.sel_a;
    data_n    = gnt_b ? bus.data_b : bus.data_a;
    state_d   = IDLE;
    rr_last_d = rr_last_q;
    side_d    = side_q;
    split_d   = split_q;
    sel_d     = sel_q;
    data_hi_d = data_hi_q;
    e_d       = '0;
    fun_sel_d = 3'b000;
    i_d       = '0;
    fin       = 1'b0;
    if (state_q == IDLE && (bus.req_a || bus.req_b)) begin
      state_d   = BEAT1;
      rr_last_d = gnt_b;
      side_d    = gnt_b;
      split_d   = cmd_n[3];
      sel_d     = sel_n;
      data_hi_d = data_n[15:8];
      e_d       = onehot(sel_n);
      fun_sel_d = cmd_n[3] ? 3'b101 : cmd_n[2:0];
      i_d       = cmd_n[3] ? {8'h00, data_n[7:0]} : data_n;
      fin       = ~cmd_n[3];
    end else if (state_q == BEAT1 && split_q) begin
      state_d   = BEAT2;
      e_d       = onehot(sel_q);
      fun_sel_d = 3'b110;
      i_d       = {8'h00, data_hi_q};
      fin       = 1'b1;
    end
    ack_a_d = fin & ~side_d;
    ack_b_d = fin & side_d;
    err_d   = fin & ~in_rng(sel_d);
    busy_d  = state_d != IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= IDLE;
      rr_last_q <= 1'b1;
      side_q    <= 1'b0;
      split_q   <= 1'b0;
      sel_q     <= '0;
      data_hi_q <= '0;
      e_q       <= '0;
      fun_sel_q <= 3'b000;
      i_q       <= '0;
      ack_a_q   <= 1'b0;
      ack_b_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      side_q    <= side_d;
      split_q   <= split_d;
      sel_q     <= sel_d;
      data_hi_q <= data_hi_d;
      e_q       <= e_d;
      fun_sel_q <= fun_sel_d;
      i_q       <= i_d;
      ack_a_q   <= ack_a_d;
      ack_b_q   <= ack_b_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  assign bus.e       = e_q;
  assign bus.fun_sel = fun_sel_q;
  assign bus.i_data  = i_q;
  assign bus.ack_a   = ack_a_q;
  assign bus.ack_b   = ack_b_q;
  assign bus.err     = err_q;
  assign bus.busy    = busy_q;
endmodule

// File: tb/tb_reg_access_arbiter.sv
// tb_reg_access_arbiter: directed checks of arbitration, beat sequencing, reset and out-of-range select
module tb_reg_access_arbiter;
  logic clk, rst;
  int   n_chk, n_err;
  logic [15:0] rf [4];
  reg_access_arbiter_if #(.NUM_REGS(4), .SEL_W(2)) bus ();
  reg_access_arbiter_if #(.NUM_REGS(3), .SEL_W(2)) bus3 ();
  reg_access_arbiter #(.NUM_REGS(4), .SEL_W(2)) u_dut (.clk(clk), .rst(rst), .bus(bus));
  reg_access_arbiter #(.NUM_REGS(3), .SEL_W(2)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [15:0] apply(input logic [15:0] r, input logic [2:0] f, input logic [15:0] d);
    case (f)
      3'b000:  return r - 16'd1;
      3'b001:  return r + 16'd1;
      3'b010:  return d;
      3'b011:  return 16'h0000;
      3'b100:  return {8'h00, d[7:0]};
      3'b101:  return {r[15:8], d[7:0]};
      3'b110:  return {d[7:0], r[7:0]};
      default: return {{8{d[7]}}, d[7:0]};
    endcase
  endfunction
  always @(posedge clk)
    for (int r = 0; r < 4; r++)
      if (bus.e[r]) rf[r] <= apply(rf[r], bus.fun_sel, bus.i_data);
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    {bus.req_a, bus.cmd_a, bus.sel_a, bus.data_a, bus.req_b, bus.cmd_b, bus.sel_b, bus.data_b} = '0;
    {bus3.req_a, bus3.cmd_a, bus3.sel_a, bus3.data_a, bus3.req_b, bus3.cmd_b, bus3.sel_b, bus3.data_b} = '0;
    tick();
    tick();
    chk("rst_e", 32'(bus.e), 32'h0);
    chk("rst_fun", 32'(bus.fun_sel), 32'h0);
    chk("rst_i", 32'(bus.i_data), 32'h0);
    chk("rst_ack_busy_err", {bus.ack_a, bus.ack_b, bus.err, bus.busy}, 32'h0);
    rst = 1'b0;
    bus.req_a = 1'b1; bus.cmd_a = 4'b0010; bus.sel_a = 2'd2; bus.data_a = 16'hBEEF;
    tick();
    chk("t1_e", 32'(bus.e), 32'b0100);
    chk("t1_fun", 32'(bus.fun_sel), 32'b010);
    chk("t1_i", 32'(bus.i_data), 32'hBEEF);
    chk("t1_ack_a", 32'(bus.ack_a), 32'h1);
    chk("t1_busy", 32'(bus.busy), 32'h1);
    bus.req_a = 1'b0;
    tick();
    chk("t1_idle_outs", {bus.e, bus.fun_sel, bus.i_data, bus.ack_a, bus.ack_b, bus.err, bus.busy}, 32'h0);
    chk("t1_r2", 32'(rf[2]), 32'hBEEF);
    bus.req_b = 1'b1; bus.cmd_b = 4'b1000; bus.sel_b = 2'd1; bus.data_b = 16'h12C4;
    tick();
    chk("t2_b1_e", 32'(bus.e), 32'b0010);
    chk("t2_b1_fun", 32'(bus.fun_sel), 32'b101);
    chk("t2_b1_i", 32'(bus.i_data), 32'h00C4);
    chk("t2_b1_ack_b", 32'(bus.ack_b), 32'h0);
    bus.req_b = 1'b0;
    tick();
    chk("t2_b2_e", 32'(bus.e), 32'b0010);
    chk("t2_b2_fun", 32'(bus.fun_sel), 32'b110);
    chk("t2_b2_i", 32'(bus.i_data), 32'h0012);
    chk("t2_b2_ack_b", 32'(bus.ack_b), 32'h1);
    tick();
    chk("t2_idle_busy", 32'(bus.busy), 32'h0);
    chk("t2_r1", 32'(rf[1]), 32'h12C4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req_a = 1'b1; bus.cmd_a = 4'b0010; bus.sel_a = 2'd0; bus.data_a = 16'h1111;
    bus.req_b = 1'b1; bus.cmd_b = 4'b0010; bus.sel_b = 2'd3; bus.data_b = 16'h2222;
    for (int n = 0; n < 4; n++) begin
      tick();
      chk("t3_ack_a", 32'(bus.ack_a), (n % 2 == 0) ? 32'h1 : 32'h0);
      chk("t3_ack_b", 32'(bus.ack_b), (n % 2 == 0) ? 32'h0 : 32'h1);
      chk("t3_e", 32'(bus.e), (n % 2 == 0) ? 32'b0001 : 32'b1000);
      tick();
      chk("t3_turnaround", {bus.e, bus.ack_a, bus.ack_b, bus.busy}, 32'h0);
    end
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    chk("t3_r0", 32'(rf[0]), 32'h1111);
    chk("t3_r3", 32'(rf[3]), 32'h2222);
    bus.req_a = 1'b1; bus.cmd_a = 4'b0010; bus.sel_a = 2'd3; bus.data_a = 16'hFFFE;
    tick();
    bus.cmd_a = 4'b0001;
    tick();
    chk("t4_load", 32'(rf[3]), 32'hFFFE);
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("t4_inc_ack", {bus.ack_a, bus.fun_sel}, 32'b1001);
      tick();
      chk("t4_inc_val", 32'(rf[3]), (n == 0) ? 32'hFFFF : (n == 1) ? 32'h0000 : 32'h0001);
    end
    bus.req_a = 1'b0;
    bus.req_a = 1'b1; bus.cmd_a = 4'b1000; bus.sel_a = 2'd0; bus.data_a = 16'hA55A;
    tick();
    chk("t5_b1_fun", 32'(bus.fun_sel), 32'b101);
    bus.req_a = 1'b0;
    tick();
    chk("t5_b2_fun", 32'(bus.fun_sel), 32'b110);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_async_outs", {bus.e, bus.fun_sel, bus.i_data, bus.ack_a, bus.busy}, 32'h0);
    tick();
    rst = 1'b0;
    chk("t5_r0", 32'(rf[0]), 32'h115A);
    bus3.req_a = 1'b1; bus3.cmd_a = 4'b1000; bus3.sel_a = 2'd3; bus3.data_a = 16'h5678;
    tick();
    chk("t6_b1_e", 32'(bus3.e), 32'h0);
    chk("t6_b1", {bus3.fun_sel, bus3.i_data, bus3.ack_a, bus3.err}, {3'b101, 16'h0078, 2'b00});
    bus3.cmd_a = 4'b0010;
    tick();
    chk("t6_b2_e", 32'(bus3.e), 32'h0);
    chk("t6_b2", {bus3.fun_sel, bus3.i_data, bus3.ack_a, bus3.err}, {3'b110, 16'h0056, 2'b11});
    tick();
    chk("t6_idle_err", {bus3.err, bus3.busy}, 32'h0);
    tick();
    chk("t6_single", {bus3.e, bus3.ack_a, bus3.err}, 32'b00011);
    bus3.sel_a = 2'd2;
    tick();
    tick();
    chk("t6_inrange", {bus3.e, bus3.ack_a, bus3.err}, 32'b10010);
    bus3.req_a = 1'b0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/reg_access_arbiter.md
Name: reg_access_arbiter

Overview:
- Shares a bank of NUM_REGS 16-bit general registers between two requesters, A and B, using round-robin arbitration.
- Each register has per-register E, plus a shared FunSel/I bus with the standard 3-bit codes: 000 dec, 001 inc, 010 load, 011 clear, 100 load-low-zero-high, 101 write-low, 110 write-high, 111 sign-extend-low.
- Translates each granted command into one or two register beats.
- Sits between the control unit / memory interface and the register bank.

Parameters:
NUM_REGS, 4, number of registers driven (legal range 2..16)
SEL_W, 2, width of register select (ceil(log2(NUM_REGS)), minimum 1)

Ports:
Clock  input  1  system clock, all state on rising edge
Reset  input  1  asynchronous, active-high reset
ReqA  input  1  requester A request, held until AckA
CmdA  input  4  bit3=1: split 16-bit load; bit3=0: single beat, FunSel=CmdA[2:0]
SelA  input  SEL_W  target register index for A
DataA  input  16  operand for A
ReqB, CmdB, SelB, DataB  input  1/4/SEL_W/16  same as A, for requester B
E  output  NUM_REGS  one-hot register enable
FunSel  output  3  function code to registers
I  output  16  data to registers
AckA  output  1  one-cycle pulse in A's final beat cycle
AckB  output  1  one-cycle pulse in B's final beat cycle
Err  output  1  pulses with Ack when Sel >= NUM_REGS
Busy  output  1  high whenever state != IDLE

Behaviour:
- All outputs are registered. Reset values: E=0, FunSel=000, I=0, AckA=AckB=Err=Busy=0, state=IDLE, rr_last=B.
- States: IDLE, BEAT1, BEAT2.
- IDLE:
  - Requests are sampled only in IDLE.
  - Only one requester high: grant it.
  - Both high: grant the requester other than rr_last. After reset, A wins the first tie.
  - On grant: latch Cmd/Sel/Data, update rr_last, go to BEAT1.
  - No request: stay in IDLE with all outputs 0.
- BEAT1:
  - Single command (Cmd[3]=0): E=onehot(Sel), FunSel=Cmd[2:0], I=Data. Ack of the granted side=1. Next state IDLE.
  - Split command (Cmd[3]=1): E=onehot(Sel), FunSel=101, I={8'h00,Data[7:0]}. No Ack. Next state BEAT2.
- BEAT2 (split only): E=onehot(Sel), FunSel=110, I={8'h00,Data[15:8]}, Ack=1. Next state IDLE.
- Latency from the sampling edge k in IDLE:
  - Single command: beat and Ack in cycle k+1; register updates at edge k+2.
  - Split command: beats in cycles k+1 and k+2, Ack in k+2; high byte lands at edge k+3.
- At least one IDLE cycle separates consecutive grants (turnaround).
- Requester protocol: drop Req, or present a new command, at the edge ending the Ack cycle. The arbiter never samples during beats.
- Req dropped before Ack: the command still completes, using the latched values.
- Out-of-range Sel (NUM_REGS not a power of two):
  - E stays all-zero for every beat; FunSel and I are driven as normal.
  - The beat count is unchanged.
  - Err=1 in the Ack cycle.
- Cmd[3]=1 ignores Cmd[2:0].
- Reset asserted mid-operation:
  - All outputs clear immediately, asynchronously; state=IDLE, rr_last=B.
  - An interrupted split leaves the low byte written and the high byte untouched. This is the defined behaviour.
- Only one E bit is ever high. E is never high in IDLE.

Test Plan:
1. Reset, then ReqA, CmdA=0010, SelA=2, DataA=16'hBEEF -> next cycle E=0100, FunSel=010, I=BEEF, AckA=1; then IDLE with all outputs 0.
2. ReqB, CmdB=1000, SelB=1, DataB=16'h12C4 -> cycle1: E=0010, FunSel=101, I=00C4; cycle2: FunSel=110, I=0012, AckB=1; a Register model holds 12C4.
3. ReqA and ReqB both held continuously, each with a single command -> grants alternate A, B, A, B with one IDLE cycle between them; first grant goes to A after reset.
4. ReqA, CmdA=0001 (inc) on register 3, repeated 3 times from 16'hFFFE -> Register model wraps FFFE -> FFFF -> 0000 -> 0001, with one AckA per command.
5. Reset asserted during BEAT2 of a split load, DataA=16'hA55A -> E=0, FunSel=0, Busy=0 immediately; register low byte=5A, high byte unchanged.
6. NUM_REGS=3, ReqA with SelA=3 -> E=000 throughout, AckA=1 and Err=1 in the same cycle, no register changes.
